// File: rtl/condicionador_sensores.sv
// -----------------------------------------------------------------------------
// condicionador_sensores
//
// Sensor front-end for the irrigation controller. It turns the three raw
// tank-level switches into clean H/M/L levels. It also raises a latched error
// flag E for two causes: a physically impossible level pattern, or a fill
// command that produces no level change for too long.
//
// Ports
//   Clock       in   system clock, all state on the rising edge
//   Reset       in   synchronous, active-high reset (overrides everything)
//   raw_h/m/l   in   raw level switches, asynchronous to Clock
//   S_Enchendo  in   fill-valve command from the controller
//   Limpa_Erro  in   operator error-clear request (level-sampled)
//   H, M, L     out  debounced levels
//   E           out  error flag, high exactly while the FSM is in ERRO
//   Nivel[1:0]  out  encoded level: 0 empty, 1 L, 2 L+M, 3 L+M+H (0 if implausible)
//   Cod_Erro    out  latched cause: bit0 implausible sensors, bit1 fill timeout
// -----------------------------------------------------------------------------
module condicionador_sensores #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ERRO_CYCLES     = 8,
  parameter int FILL_TIMEOUT    = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       raw_h,
  input  logic       raw_m,
  input  logic       raw_l,
  input  logic       S_Enchendo,
  input  logic       Limpa_Erro,
  output logic       H,
  output logic       M,
  output logic       L,
  output logic       E,
  output logic [1:0] Nivel,
  output logic [1:0] Cod_Erro
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW  = $clog2(ERRO_CYCLES + 1);
  localparam int FW  = $clog2(FILL_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_SUSPEITO = 2'd1,
    ST_ERRO     = 2'd2
  } estado_t;

  // Channel index: 2 = high, 1 = mid, 0 = low.
  logic [2:0]     s1_q, s2_q;
  logic [2:0]     deb_q, deb_d;
  logic [DBW-1:0] dbc_q [3];
  logic [DBW-1:0] dbc_d [3];

  estado_t        state_q, state_d;
  logic [PW-1:0]  pers_q, pers_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic [1:0]     cod_q, cod_d;

  logic implaus;
  logic deb_change;
  logic pers_hit;
  logic fill_hit;

  // Debounce: the counter tracks how many consecutive edges the synchronised
  // input has disagreed with the debounced value. Reaching the threshold
  // takes the new value; any agreeing edge restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      dbc_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (dbc_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = s2_q[i];
          dbc_d[i] = '0;
        end else begin
          dbc_d[i] = dbc_q[i] + DBW'(1);
        end
      end
    end
  end

  // A switch above cannot be wet while a switch below it is dry.
  assign implaus = (deb_q[2] & ~deb_q[1]) | (deb_q[2] & ~deb_q[0]) |
                   (deb_q[1] & ~deb_q[0]);

  always_comb begin
    Nivel = 2'd0;
    if (!implaus) begin
      if (deb_q[2] & deb_q[1] & deb_q[0]) Nivel = 2'd3;
      else if (deb_q[1] & deb_q[0])       Nivel = 2'd2;
      else if (deb_q[0])                  Nivel = 2'd1;
      else                                Nivel = 2'd0;
    end
  end

  // A debounced level flip this edge counts as the tank responding to filling.
  assign deb_change = (deb_d != deb_q);

  always_comb begin
    state_d  = state_q;
    pers_d   = pers_q;
    fill_d   = fill_q;
    cod_d    = cod_q;
    pers_hit = 1'b0;
    fill_hit = 1'b0;
    case (state_q)
      ST_OK, ST_SUSPEITO: begin
        // Persistence counter: starts at 1 on the first implausible edge.
        if (implaus) begin
          if (pers_q < PW'(ERRO_CYCLES)) pers_d = pers_q + PW'(1);
          pers_hit = (pers_d == PW'(ERRO_CYCLES));
        end else begin
          pers_d = '0;
        end
        // Fill timer: only counts while filling with no visible progress.
        if (!S_Enchendo || deb_change || (Nivel == 2'd3)) begin
          fill_d = '0;
        end else if (fill_q < FW'(FILL_TIMEOUT)) begin
          fill_d = fill_q + FW'(1);
        end
        fill_hit = (fill_d == FW'(FILL_TIMEOUT));

        if (pers_hit || fill_hit) begin
          state_d = ST_ERRO;
          cod_d   = {fill_hit, pers_hit};
          pers_d  = '0;
          fill_d  = '0;
        end else if (implaus) begin
          state_d = ST_SUSPEITO;
        end else begin
          state_d = ST_OK;
        end
      end
      ST_ERRO: begin
        pers_d = '0;
        fill_d = '0;
        // Clearing is refused while the sensors still disagree.
        if (Limpa_Erro && !implaus) begin
          state_d = ST_OK;
          cod_d   = 2'b00;
        end
      end
      default: begin
        state_d = ST_OK;
        pers_d  = '0;
        fill_d  = '0;
        cod_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 3; i++) dbc_q[i] <= '0;
      state_q <= ST_OK;
      pers_q  <= '0;
      fill_q  <= '0;
      cod_q   <= 2'b00;
    end else begin
      s1_q    <= {raw_h, raw_m, raw_l};
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < 3; i++) dbc_q[i] <= dbc_d[i];
      state_q <= state_d;
      pers_q  <= pers_d;
      fill_q  <= fill_d;
      cod_q   <= cod_d;
    end
  end

  assign H        = deb_q[2];
  assign M        = deb_q[1];
  assign L        = deb_q[0];
  assign E        = (state_q == ST_ERRO);
  assign Cod_Erro = cod_q;

endmodule

// File: tb/tb_condicionador_sensores.sv
// -----------------------------------------------------------------------------
// tb_condicionador_sensores
//
// Directed bench. Drivers change inputs on the falling edge and queue the
// outputs expected after a given rising edge (counted by edge_n). A monitor
// on every falling edge pops the entries due for that edge and compares.
// Packed expectation: {H, M, L, E, Nivel[1:0], Cod_Erro[1:0]}.
// -----------------------------------------------------------------------------
module tb_condicionador_sensores;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       raw_h = 1'b0;
  logic       raw_m = 1'b0;
  logic       raw_l = 1'b0;
  logic       S_Enchendo = 1'b0;
  logic       Limpa_Erro = 1'b0;
  logic       H, M, L, E;
  logic [1:0] Nivel, Cod_Erro;

  condicionador_sensores dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .raw_h      (raw_h),
    .raw_m      (raw_m),
    .raw_l      (raw_l),
    .S_Enchendo (S_Enchendo),
    .Limpa_Erro (Limpa_Erro),
    .H          (H),
    .M          (M),
    .L          (L),
    .E          (E),
    .Nivel      (Nivel),
    .Cod_Erro   (Cod_Erro)
  );

  // ---------------- clock / edge counter ----------------
  always #5 Clock = ~Clock;

  int edge_n = 0;
  always @(posedge Clock) edge_n <= edge_n + 1;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         cyc_q[$];
  string      name_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  function automatic logic [7:0] pk(input logic h, input logic m, input logic l,
                                    input logic e, input logic [1:0] niv,
                                    input logic [1:0] cod);
    return {h, m, l, e, niv, cod};
  endfunction

  // Sorted insert so entries are always popped in edge order.
  task automatic expect_at(input int cyc, input logic [7:0] v, input string nm);
    int idx;
    idx = cyc_q.size();
    for (int i = 0; i < cyc_q.size(); i++) begin
      if (cyc_q[i] > cyc) begin
        idx = i;
        break;
      end
    end
    cyc_q.insert(idx, cyc);
    exp_q.insert(idx, v);
    name_q.insert(idx, nm);
  endtask

  always @(negedge Clock) begin
    while (cyc_q.size() > 0 && cyc_q[0] <= edge_n) begin
      int         c;
      logic [7:0] ex;
      logic [7:0] got;
      string      nm;
      c   = cyc_q.pop_front();
      ex  = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {H, M, L, E, Nivel, Cod_Erro};
      n_checks++;
      if (c != edge_n) begin
        $display("FAIL %s: check for edge %0d reached late at edge %0d", nm, c, edge_n);
      end else if (got !== ex) begin
        $display("FAIL %s @edge %0d: got HMLE=%b Nivel=%0d Cod=%b, expected HMLE=%b Nivel=%0d Cod=%b",
                 nm, edge_n, got[7:4], got[3:2], got[1:0], ex[7:4], ex[3:2], ex[1:0]);
      end else begin
        n_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic reset_dut();
    @(negedge Clock);
    Reset      = 1'b1;
    raw_h      = 1'b0;
    raw_m      = 1'b0;
    raw_l      = 1'b0;
    S_Enchendo = 1'b0;
    Limpa_Erro = 1'b0;
    expect_at(edge_n + 1, pk(0, 0, 0, 0, 2'd0, 2'b00), "reset_state");
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int base;
  int t;

  initial begin
    // Test 1: L latency and a short raw_h pulse that must be filtered.
    reset_dut();
    base = edge_n;
    raw_l = 1'b1;
    expect_at(base + 5, pk(0, 0, 0, 0, 2'd0, 2'b00), "t1_l_not_yet");
    expect_at(base + 6, pk(0, 0, 1, 0, 2'd1, 2'b00), "t1_l_set");
    step(8);
    t = edge_n;
    for (int k = 1; k <= 10; k++) expect_at(t + k, pk(0, 0, 1, 0, 2'd1, 2'b00), "t1_pulse_filtered");
    raw_h = 1'b1;
    step(3);
    raw_h = 1'b0;
    step(8);

    // Test 2: H without M -> error after ERRO_CYCLES debounced edges.
    reset_dut();
    base = edge_n;
    raw_h = 1'b1;
    raw_l = 1'b1;
    expect_at(base + 6,  pk(1, 0, 1, 0, 2'd0, 2'b00), "t2_implaus_nivel0");
    expect_at(base + 13, pk(1, 0, 1, 0, 2'd0, 2'b00), "t2_pre_err");
    expect_at(base + 14, pk(1, 0, 1, 1, 2'd0, 2'b01), "t2_err_implaus");
    step(16);

    // Test 5: clear refused while implausible, accepted once fixed.
    t = edge_n;
    Limpa_Erro = 1'b1;
    expect_at(t + 1, pk(1, 0, 1, 1, 2'd0, 2'b01), "t5_clear_refused");
    expect_at(t + 3, pk(1, 0, 1, 1, 2'd0, 2'b01), "t5_still_err");
    step(1);
    Limpa_Erro = 1'b0;
    step(2);
    base = edge_n;
    raw_m = 1'b1;
    expect_at(base + 6, pk(1, 1, 1, 1, 2'd3, 2'b01), "t5_fixed_err_held");
    step(7);
    Limpa_Erro = 1'b1;
    expect_at(edge_n + 1, pk(1, 1, 1, 0, 2'd3, 2'b00), "t5_cleared");
    step(1);
    Limpa_Erro = 1'b0;
    expect_at(edge_n + 2, pk(1, 1, 1, 0, 2'd3, 2'b00), "t5_stays_ok");
    step(3);

    // Test 3: short implausible spell, then a full re-count.
    reset_dut();
    base = edge_n;
    raw_h = 1'b1;
    raw_l = 1'b1;
    expect_at(base + 6,  pk(1, 0, 1, 0, 2'd0, 2'b00), "t3_implaus");
    expect_at(base + 10, pk(1, 0, 1, 0, 2'd0, 2'b00), "t3_suspeito");
    step(5);
    raw_m = 1'b1;
    for (int k = 11; k <= 20; k++) expect_at(base + k, pk(1, 1, 1, 0, 2'd3, 2'b00), "t3_no_err");
    step(15);
    raw_m = 1'b0;
    expect_at(base + 26, pk(1, 0, 1, 0, 2'd0, 2'b00), "t3_reimplaus");
    expect_at(base + 33, pk(1, 0, 1, 0, 2'd0, 2'b00), "t3_pers_restarted");
    expect_at(base + 34, pk(1, 0, 1, 1, 2'd0, 2'b01), "t3_full_count_err");
    step(16);

    // Test 4a: fill timeout at a stable Nivel=1.
    reset_dut();
    raw_l = 1'b1;
    step(8);
    base = edge_n;
    S_Enchendo = 1'b1;
    expect_at(base + 15, pk(0, 0, 1, 0, 2'd1, 2'b00), "t4_pre_timeout");
    expect_at(base + 16, pk(0, 0, 1, 1, 2'd1, 2'b10), "t4_timeout");
    step(18);

    // Test 4b: M flips at counted edge 10, timer restarts.
    reset_dut();
    raw_l = 1'b1;
    step(8);
    base = edge_n;
    S_Enchendo = 1'b1;
    expect_at(base + 10, pk(0, 1, 1, 0, 2'd2, 2'b00), "t4_m_flip");
    expect_at(base + 16, pk(0, 1, 1, 0, 2'd2, 2'b00), "t4_timer_restarted");
    expect_at(base + 25, pk(0, 1, 1, 0, 2'd2, 2'b00), "t4_pre_timeout2");
    expect_at(base + 26, pk(0, 1, 1, 1, 2'd2, 2'b10), "t4_timeout2");
    step(4);
    raw_m = 1'b1;
    step(24);
    S_Enchendo = 1'b0;

    // Test 6a: reset mid-debounce restarts the full latency.
    reset_dut();
    base = edge_n;
    raw_l = 1'b1;
    step(3);
    Reset = 1'b1;
    expect_at(base + 4, pk(0, 0, 0, 0, 2'd0, 2'b00), "t6_rst_mid_deb");
    step(1);
    Reset = 1'b0;
    expect_at(base + 6,  pk(0, 0, 0, 0, 2'd0, 2'b00), "t6_no_early_l");
    expect_at(base + 9,  pk(0, 0, 0, 0, 2'd0, 2'b00), "t6_restart_wait");
    expect_at(base + 10, pk(0, 0, 1, 0, 2'd1, 2'b00), "t6_full_latency");
    step(8);

    // Test 6b: reset while E=1.
    reset_dut();
    base = edge_n;
    raw_h = 1'b1;
    raw_l = 1'b1;
    expect_at(base + 16, pk(1, 0, 1, 1, 2'd0, 2'b01), "t6_in_err");
    step(16);
    Reset = 1'b1;
    expect_at(base + 17, pk(0, 0, 0, 0, 2'd0, 2'b00), "t6_rst_in_err");
    step(1);
    Reset = 1'b0;
    expect_at(base + 22, pk(0, 0, 0, 0, 2'd0, 2'b00), "t6_after_rst_wait");
    expect_at(base + 23, pk(1, 0, 1, 0, 2'd0, 2'b00), "t6_after_rst_deb");
    step(8);

    // ---------------- final report ----------------
    for (int k = 0; k < 50 && cyc_q.size() > 0; k++) @(negedge Clock);
    while (cyc_q.size() > 0) begin
      n_checks++;
      $display("FAIL %s: expected at edge %0d never compared", name_q[0], cyc_q[0]);
      void'(cyc_q.pop_front());
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
